rr_arbiter8: RTL and testbench

Eight-way round-robin arbiter that shares one datapath resource (a shared bus or memory port) between up to eight requesters. Each arbitration picks a 3-bit winner index and drives it both encoded and as a one-hot grant vector, using the same 3-to-8 decode the datapath uses for select lines. A grant is held until the owner signals completion, drops its request, or exceeds a programmable hold limit. Fairness comes from a rotating priority pointer.

---
 rtl/rr_arbiter8.sv | 118 +++++++++++
 tb/tb_rr_arbiter8.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with rotating priority pointer,
// done/drop release and an optional hold-limit timeout.
module rr_arbiter8 #(
    parameter int HOLD_LIMIT = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam bit               LIMITED = (HOLD_LIMIT != 0);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(HOLD_LIMIT - 1);

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [7:0]  eligible;
    logic [15:0] dbl;
    logic [7:0]  rot;
    logic [2:0]  off;
    logic [2:0]  winner;
    logic        any;
    logic        rel_done;
    logic        rel_drop;
    logic        rel_hold;
    logic        rel;

    function automatic logic [7:0] decode(input logic [2:0] idx);
        logic [7:0] onehot;
        onehot = 8'h00;
        unique case (idx)
            3'd0: onehot = 8'h01;
            3'd1: onehot = 8'h02;
            3'd2: onehot = 8'h04;
            3'd3: onehot = 8'h08;
            3'd4: onehot = 8'h10;
            3'd5: onehot = 8'h20;
            3'd6: onehot = 8'h40;
            3'd7: onehot = 8'h80;
        endcase
        return onehot;
    endfunction

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        eligible = req & ~mask;
        any      = |eligible;
        dbl      = {eligible, eligible};
        rot      = dbl[ptr +: 8];
        off      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
        winner = ptr + off;
    end

    always_comb begin
        rel_done = done;
        rel_drop = ~req[grant_idx];
        rel_hold = LIMITED && (cnt == LAST);
        rel      = rel_done | rel_drop | rel_hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            cnt         <= '0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        state       <= BUSY;
                        grant_idx   <= winner;
                        grant       <= decode(winner);
                        grant_valid <= 1'b1;
                        cnt         <= '0;
                        ptr         <= winner + 3'd1;
                    end
                end
                BUSY: begin
                    if (rel) begin
                        state       <= IDLE;
                        grant       <= 8'h00;
                        grant_valid <= 1'b0;
                        cnt         <= '0;
                        // Only a pure hold-limit revoke is flagged.
                        timeout     <= rel_hold & ~rel_done & ~rel_drop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 against a cycle-level
// behavioural model of the round-robin arbitration rules.
module tb_rr_arbiter8;

    localparam int L = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_busy;
    bit m_to;
    int m_ptr;
    int m_cnt;
    int m_idx;

    rr_arbiter8 #(
        .HOLD_LIMIT(L),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .mask(mask),
        .done(done),
        .grant(grant),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        g = 8'h00;
        if (m_busy) g[m_idx] = 1'b1;
        return {g, 3'(m_idx), m_busy, m_to};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {grant, grant_idx, grant_valid, timeout};
    endfunction

    task automatic model_step(input logic [7:0] r, input logic [7:0] mk,
                              input logic d, input logic rs);
        logic [7:0] elig;
        bit a, b, c, found;
        int w;
        if (rs) begin
            m_busy = 0; m_to = 0; m_ptr = 0; m_cnt = 0; m_idx = 0;
        end else if (!m_busy) begin
            m_to = 0;
            elig = r & ~mk;
            found = 0;
            w = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && elig[(m_ptr + k) % 8]) begin
                    found = 1;
                    w = (m_ptr + k) % 8;
                end
            end
            if (found) begin
                m_busy = 1; m_idx = w; m_cnt = 0; m_ptr = (w + 1) % 8;
            end
        end else begin
            a = d;
            b = !r[m_idx];
            c = (L != 0) && (m_cnt == L - 1);
            if (a || b || c) begin
                m_busy = 0; m_cnt = 0; m_to = c && !a && !b;
            end else begin
                m_cnt++; m_to = 0;
            end
        end
    endtask

    task automatic tick(input logic [7:0] r, input logic [7:0] mk,
                        input logic d, input logic rs);
        req = r; mask = mk; done = d; rst = rs;
        @(posedge clk);
        model_step(r, mk, d, rs);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(8'hFF, 8'h00, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== 13'h0) begin
                errors++;
                $display("FAIL reset_%0d got %h exp %h", i, obs_vec(), 13'h0);
            end
        end
        tick(8'hFF, 8'h00, 1'b0, 1'b0);
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got %h/%0d exp 01/0", grant, grant_idx);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] e;
        tick(8'hFF, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick(8'hFF, 8'h00, 1'b0, 1'b0);
            e = 3'(i % 8);
            checks++;
            if (grant_idx !== e || grant_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr_grant_%0d got idx %0d v %b exp idx %0d", i, grant_idx, grant_valid, e);
            end
            tick(8'hFF, 8'h00, 1'b1, 1'b0);
            checks++;
            if (grant_valid !== 1'b0 || grant !== 8'h00) begin
                errors++;
                $display("FAIL rr_idle_%0d got %h exp 00", i, grant);
            end
        end
    endtask

    task automatic test_wrap_skip();
        bit bad;
        bad = 0;
        tick(8'h00, 8'h00, 1'b0, 1'b1);
        tick(8'h02, 8'h00, 1'b0, 1'b0);
        tick(8'h02, 8'h00, 1'b1, 1'b0);
        tick(8'h82, 8'h00, 1'b0, 1'b0);
        if (grant[6:2] !== 5'b0) bad = 1;
        checks++;
        if (grant_idx !== 3'd7 || grant !== 8'h80) begin
            errors++;
            $display("FAIL wrap_to_7 got idx %0d grant %h exp 7/80", grant_idx, grant);
        end
        tick(8'h82, 8'h00, 1'b1, 1'b0);
        if (grant[6:2] !== 5'b0) bad = 1;
        tick(8'h82, 8'h00, 1'b0, 1'b0);
        if (grant[6:2] !== 5'b0) bad = 1;
        checks++;
        if (grant_idx !== 3'd1 || grant !== 8'h02) begin
            errors++;
            $display("FAIL wrap_to_1 got idx %0d grant %h exp 1/02", grant_idx, grant);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL skip_2_6 got a grant in bits 6:2 exp none");
        end
    endtask

    task automatic test_timeout();
        int n;
        tick(8'h00, 8'h00, 1'b0, 1'b1);
        tick(8'h08, 8'h00, 1'b0, 1'b0);
        n = 0;
        while (grant === 8'h08 && n < 20) begin
            n++;
            tick(8'h08, 8'h00, 1'b0, 1'b0);
        end
        checks++;
        if (n !== L) begin
            errors++;
            $display("FAIL timeout_len got %0d exp %0d", n, L);
        end
        checks++;
        if (timeout !== 1'b1 || grant !== 8'h00 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_pulse got to %b grant %h exp to 1 grant 00", timeout, grant);
        end
        tick(8'h08, 8'h00, 1'b0, 1'b0);
        checks++;
        if (timeout !== 1'b0 || grant !== 8'h08) begin
            errors++;
            $display("FAIL timeout_regrant got to %b grant %h exp to 0 grant 08", timeout, grant);
        end
    endtask

    task automatic test_coincident();
        tick(8'h00, 8'h00, 1'b0, 1'b1);
        tick(8'h08, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(8'h08, 8'h00, 1'b0, 1'b0);
        tick(8'h08, 8'h00, 1'b1, 1'b0);
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL coincident_done got grant %h to %b exp 00/0", grant, timeout);
        end
        tick(8'h08, 8'h00, 1'b0, 1'b0);
        tick(8'h08, 8'h00, 1'b0, 1'b0);
        tick(8'h00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (grant !== 8'h00 || timeout !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL drop_req got grant %h to %b exp 00/0", grant, timeout);
        end
    endtask

    task automatic test_mask_reset();
        tick(8'h00, 8'h00, 1'b0, 1'b1);
        tick(8'h03, 8'h01, 1'b0, 1'b0);
        checks++;
        if (grant_idx !== 3'd1 || grant !== 8'h02) begin
            errors++;
            $display("FAIL mask_pick got idx %0d exp 1", grant_idx);
        end
        tick(8'h03, 8'h02, 1'b0, 1'b0);
        tick(8'h03, 8'h02, 1'b0, 1'b0);
        checks++;
        if (grant !== 8'h02 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL mask_mid_grant got %h exp 02", grant);
        end
        tick(8'h03, 8'h02, 1'b0, 1'b1);
        checks++;
        if (obs_vec() !== 13'h0) begin
            errors++;
            $display("FAIL mid_reset got %h exp %h", obs_vec(), 13'h0);
        end
        tick(8'hFF, 8'h00, 1'b0, 1'b0);
        checks++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL ptr_after_reset got %h exp 01", grant);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic [7:0] mk;
        r = 8'h00;
        tick(8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            mk = 8'($urandom) & 8'($urandom);
            tick(r, mk, ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (obs_vec() !== exp_vec() || grant_valid !== (|grant)) begin
                errors++;
                $display("FAIL random_%0d got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; mask = 8'h00; done = 1'b0;
        m_busy = 0; m_to = 0; m_ptr = 0; m_cnt = 0; m_idx = 0;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_coincident();
        test_mask_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
